tx_tlp_capture: RTL and testbench

TX_TLP_CAPTURE -- requirements
Module: tx_tlp_capture

---
 rtl/tx_tlp_capture.sv | 157 +++++++++++++++
 tb/tb_tx_tlp_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_tlp_capture.sv
// TX TLP capture: framing checker feeding a first-word-fall-through record FIFO
// with packet/interrupt counters and a sticky framing-error flag.
module tx_tlp_capture #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_tvalid,
    output logic             tx_tready,
    input  logic [127:0]     tx_hdr,
    input  logic [255:0]     tx_payload,
    input  logic             tx_sop,
    input  logic             tx_eop,
    input  logic             tx_afu_irq,
    input  logic [7:0]       tx_irq_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_hdr,
    output logic [255:0]     out_payload,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_irq,
    output logic [7:0]       out_irq_id,
    output logic             err_framing,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] irq_count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [127:0] hdr;
        logic [255:0] payload;
        logic         sop;
        logic         eop;
        logic         irq;
        logic [7:0]   irq_id;
    } rec_t;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t           state_q, state_d;
    rec_t             mem_q [DEPTH];
    rec_t             wr_rec, head;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             rdy_en_q, err_q;
    logic [CNT_W-1:0] pkt_q, irq_q;
    logic             accept, push, pop;
    logic             pkt_inc, irq_inc, err_set;

    assign accept = tx_tvalid & tx_tready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && !tx_afu_irq) begin
            unique case (state_q)
                IDLE:    if (tx_sop && !tx_eop) state_d = IN_PKT;
                IN_PKT:  if (!tx_sop && tx_eop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Interrupt beats become a standalone single-beat record with no data.
    always_comb begin
        push    = 1'b0;
        pkt_inc = 1'b0;
        irq_inc = 1'b0;
        err_set = 1'b0;
        wr_rec  = '{hdr: tx_hdr, payload: tx_payload, sop: tx_sop,
                    eop: tx_eop, irq: 1'b0, irq_id: 8'h00};
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (tx_afu_irq) begin
                        push    = 1'b1;
                        irq_inc = 1'b1;
                        wr_rec  = '{hdr: '0, payload: '0, sop: 1'b1,
                                    eop: 1'b1, irq: 1'b1, irq_id: tx_irq_id};
                    end else if (tx_sop) begin
                        push    = 1'b1;
                        pkt_inc = tx_eop;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (tx_afu_irq || tx_sop) begin
                        err_set = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pkt_inc = tx_eop;
                    end
                end
                default: err_set = 1'b0;
            endcase
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
            err_q    <= 1'b0;
            pkt_q    <= '0;
            irq_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            count_q  <= count_d;
            if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (err_set) err_q    <= 1'b1;
            if (pkt_inc) pkt_q    <= pkt_q + 1'b1;
            if (irq_inc) irq_q    <= irq_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_rec;
    end

    // Ready comes from registered occupancy only, held low until the first edge out of reset.
    assign tx_tready   = rdy_en_q & (count_q < (AW+1)'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_hdr     = head.hdr;
    assign out_payload = head.payload;
    assign out_sop     = head.sop;
    assign out_eop     = head.eop;
    assign out_irq     = head.irq;
    assign out_irq_id  = head.irq_id;
    assign err_framing = err_q;
    assign pkt_count   = pkt_q;
    assign irq_count   = irq_q;

endmodule

// File: tb/tb_tx_tlp_capture.sv
// Directed bench for tx_tlp_capture: framing, FIFO ordering/backpressure,
// interrupt records, reset behaviour and counter wrap.
module tb_tx_tlp_capture;

    logic         clk, reset;
    logic         tx_tvalid, tx_tready;
    logic [127:0] tx_hdr;
    logic [255:0] tx_payload;
    logic         tx_sop, tx_eop, tx_afu_irq;
    logic [7:0]   tx_irq_id;
    logic         out_valid, out_ready;
    logic [127:0] out_hdr;
    logic [255:0] out_payload;
    logic         out_sop, out_eop, out_irq;
    logic [7:0]   out_irq_id;
    logic         err_framing;
    logic [15:0]  pkt_count, irq_count;

    logic         tready4, valid4, sop4, eop4, irq4, err4;
    logic [127:0] hdr4;
    logic [255:0] pay4;
    logic [7:0]   id4;
    logic [3:0]   pkt4, irqc4;

    int n_chk = 0;
    int n_err = 0;

    tx_tlp_capture u_dut (
        .clk(clk), .reset(reset),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_hdr(tx_hdr), .tx_payload(tx_payload),
        .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_afu_irq(tx_afu_irq), .tx_irq_id(tx_irq_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hdr(out_hdr), .out_payload(out_payload),
        .out_sop(out_sop), .out_eop(out_eop),
        .out_irq(out_irq), .out_irq_id(out_irq_id),
        .err_framing(err_framing),
        .pkt_count(pkt_count), .irq_count(irq_count)
    );

    tx_tlp_capture #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .tx_tvalid(tx_tvalid), .tx_tready(tready4),
        .tx_hdr(tx_hdr), .tx_payload(tx_payload),
        .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_afu_irq(tx_afu_irq), .tx_irq_id(tx_irq_id),
        .out_valid(valid4), .out_ready(out_ready),
        .out_hdr(hdr4), .out_payload(pay4),
        .out_sop(sop4), .out_eop(eop4),
        .out_irq(irq4), .out_irq_id(id4),
        .err_framing(err4),
        .pkt_count(pkt4), .irq_count(irqc4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the beat is accepted.
    task automatic send(input logic [127:0] h, input logic [255:0] p,
                        input logic s, input logic e,
                        input logic irq, input logic [7:0] id);
        int n;
        n = 0;
        tx_hdr     = h;
        tx_payload = p;
        tx_sop     = s;
        tx_eop     = e;
        tx_afu_irq = irq;
        tx_irq_id  = id;
        tx_tvalid  = 1'b1;
        while (!tx_tready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", tx_tready, 1);
        if (tx_tready) begin
            @(posedge clk);
            #1;
        end
        tx_tvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        clk = 0; reset = 1;
        tx_tvalid = 0; tx_hdr = '0; tx_payload = '0;
        tx_sop = 0; tx_eop = 0; tx_afu_irq = 0; tx_irq_id = '0;
        out_ready = 0;

        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", tx_tready, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_err", err_framing, 0);
        chk("rst_hdr", out_hdr, 0);
        @(negedge clk);
        reset = 0;
        chk("ready_low_pre_edge", tx_tready, 0);
        @(negedge clk);
        chk("ready_rise", tx_tready, 1);

        // single beat packet, one-cycle latency
        out_ready = 1;
        chk("t1_pre_valid", out_valid, 0);
        send(128'h1234, 256'h55, 1, 1, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_hdr", out_hdr, 128'h1234);
        chk("t1_pay", out_payload, 256'h55);
        chk("t1_sopeop", {out_sop, out_eop, out_irq}, 3'b110);
        chk("t1_pkt", pkt_count, 1);
        @(negedge clk);
        chk("t1_popped", out_valid, 0);
        chk("t1_zero_hdr", out_hdr, 0);

        // backpressure with 5 packets into a 4-deep FIFO
        out_ready = 0;
        for (int i = 0; i < 4; i++) send(128'h10 + i, i, 1, 1, 0, 0);
        chk("t2_full_ready", tx_tready, 0);
        chk("t2_head", out_hdr, 128'h10);
        tx_hdr = 128'h14; tx_payload = 4;
        tx_sop = 1; tx_eop = 1; tx_afu_irq = 0;
        tx_tvalid = 1;
        repeat (3) @(negedge clk);
        chk("t2_held_ready", tx_tready, 0);
        chk("t2_held_hdr", out_hdr, 128'h10);
        chk("t2_pkt_held", pkt_count, 5);
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_order_valid", out_valid, 1);
            chk("t2_order_hdr", out_hdr, 128'h10 + i);
            acc = tx_tvalid && tx_tready;
            @(posedge clk);
            #1;
            if (acc) tx_tvalid = 0;
            @(negedge clk);
        end
        chk("t2_empty", out_valid, 0);
        chk("t2_pkt", pkt_count, 6);
        chk("t2_no_err", err_framing, 0);

        // irq beat mid-packet is dropped
        out_ready = 0;
        send(128'hA1, 1, 1, 0, 0, 0);
        send(128'h0, 256'hEE, 0, 0, 1, 8'h07);
        send(128'h0, 2, 0, 0, 0, 0);
        send(128'h0, 3, 0, 1, 0, 0);
        chk("t3_err", err_framing, 1);
        chk("t3_irqcnt", irq_count, 0);
        chk("t3_pkt", pkt_count, 7);
        chk("t3_ready", tx_tready, 1);
        chk("t3_hdr", out_hdr, 128'hA1);
        chk("t3_sop", {out_sop, out_eop}, 2'b10);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_pay", out_payload, i + 1);
            chk("t3_irq", out_irq, 0);
            @(negedge clk);
        end
        chk("t3_empty", out_valid, 0);

        // sop=0 in IDLE and sop=1 inside a packet are dropped
        out_ready = 0;
        send(128'h99, 9, 0, 1, 0, 0);
        chk("t3b_idle_drop", out_valid, 0);
        send(128'hB, 1, 1, 0, 0, 0);
        send(128'hC, 2, 1, 1, 0, 0);
        send(128'h0, 3, 0, 1, 0, 0);
        chk("t3b_pkt", pkt_count, 8);
        out_ready = 1;
        chk("t3b_first", out_payload, 1);
        @(negedge clk);
        chk("t3b_second", out_payload, 3);
        chk("t3b_eop", out_eop, 1);
        @(negedge clk);
        chk("t3b_empty", out_valid, 0);

        // idle interrupt beat
        out_ready = 0;
        send(128'hFFFF, 256'hDEAD, 0, 0, 1, 8'h2A);
        chk("t4_valid", out_valid, 1);
        chk("t4_flags", {out_irq, out_sop, out_eop}, 3'b111);
        chk("t4_id", out_irq_id, 8'h2A);
        chk("t4_hdr", out_hdr, 0);
        chk("t4_pay", out_payload, 0);
        chk("t4_irqcnt", irq_count, 1);
        chk("t4_sticky", err_framing, 1);
        chk("t4_pkt", pkt_count, 8);
        out_ready = 1;
        @(negedge clk);
        chk("t4_empty", out_valid, 0);
        chk("t4_zero_id", out_irq_id, 0);

        // reset mid-packet with two queued entries
        out_ready = 0;
        send(128'hB0, 0, 1, 1, 0, 0);
        send(128'hB1, 0, 1, 0, 0, 0);
        chk("t5_queued", out_valid, 1);
        #2 reset = 1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", tx_tready, 0);
        chk("t5_rst_pkt", pkt_count, 0);
        chk("t5_rst_irq", irq_count, 0);
        chk("t5_rst_err", err_framing, 0);
        chk("t5_rst_hdr", out_hdr, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("t5_ready", tx_tready, 1);
        send(128'hC0, 0, 1, 0, 0, 0);
        chk("t5_no_err", err_framing, 0);
        chk("t5_valid", out_valid, 1);
        chk("t5_hdr", out_hdr, 128'hC0);
        send(128'h0, 1, 0, 1, 0, 0);
        chk("t5_pkt", pkt_count, 1);
        out_ready = 1;
        repeat (2) @(negedge clk);
        chk("t5_empty", out_valid, 0);

        // counter wrap
        reset = 1;
        #1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        out_ready = 1;
        for (int i = 0; i < 17; i++) send(i, i, 1, 1, 0, 0);
        chk("t6_pkt16", pkt_count, 17);
        chk("t6_pkt4_wrap", pkt4, 1);
        chk("t6_irq4", irqc4, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
